// File: rtl/ifetch.sv
// ifetch: instruction fetch stage with single-outstanding imem requests and a small instruction buffer.
// Optional IFETCH_MISALIGN_CHECK_EN: misaligned redirects raise fetch_fault and halt fetch.
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_SPACE, DRAIN, HALT} state_t;
    state_t state, state_nx;

    logic [31:0] fetch_pc, drain_pc, redir_pc;
    logic [31:0] mem_data [FIFO_DEPTH];
    logic [31:0] mem_pc   [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count, count_nx;
    logic push, pop, misalign;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign redir_pc = redirect_pc;
    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_pc = redirect_pc & ~32'h3;
    assign misalign = 1'b0;
`endif

    // DRAIN keeps presenting the pre-redirect address until the stale ack arrives
    assign imem_req   = (state == REQ) || (state == DRAIN);
    assign imem_addr  = (state == DRAIN) ? drain_pc : fetch_pc;
    assign inst_valid = count != '0;
    assign inst_data  = mem_data[rd_ptr];
    assign inst_pc    = mem_pc[rd_ptr];
    assign push       = (state == REQ) && imem_ack && !redirect_valid;
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign count_nx   = count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = REQ;
            REQ:        state_nx = (push && count_nx == FULL) ? WAIT_SPACE : REQ;
            WAIT_SPACE: state_nx = pop ? REQ : WAIT_SPACE;
            DRAIN:      state_nx = imem_ack ? REQ : DRAIN;
            HALT:       state_nx = HALT;
            default:    state_nx = IDLE;
        endcase
        if (redirect_valid)
            state_nx = misalign ? HALT : (imem_req && !imem_ack) ? DRAIN : REQ;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            drain_pc    <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fetch_fault <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            state       <= state_nx;
            fetch_fault <= misalign;
            fetch_pc    <= redirect_valid ? redir_pc : push ? fetch_pc + 32'd4 : fetch_pc;
            if (redirect_valid && state != DRAIN)
                drain_pc <= imem_addr;
            count  <= redirect_valid ? '0 : count_nx;
            rd_ptr <= redirect_valid ? '0 : pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= redirect_valid ? '0 : push ? wr_ptr + 1'b1 : wr_ptr;
            if (push) begin
                mem_data[wr_ptr] <= imem_rdata;
                mem_pc[wr_ptr]   <= fetch_pc;
            end
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed plus randomized stimulus against a queue-based model of the fetch stream.
module tb_ifetch;
    localparam logic [31:0] RST_PC = 32'h100;
    localparam int DEPTH = 2;

    logic        clk, rstn, redirect_valid, imem_ack, inst_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, inst_valid, fetch_fault;
    logic [31:0] imem_addr, inst_data, inst_pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] next_fetch, drain_addr;
    logic        discard, halted, fault_exp, started;

    ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .fetch_fault(fetch_fault)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_fn(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_fetch = RST_PC;
        drain_addr = RST_PC;
        discard    = 1'b0;
        halted     = 1'b0;
        fault_exp  = 1'b0;
        started    = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", inst_valid, 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_fault", fetch_fault, 0);
    endtask

    // Called at a falling edge: checks outputs, drives inputs, advances the model across one rising edge.
    task automatic cycle(input logic ack, input logic rdy, input logic rv, input logic [31:0] tgt);
        logic mreq, mvalid;
        mvalid = q.size() != 0;
        mreq = halted ? 1'b0 : discard ? 1'b1 : started ? (q.size() < DEPTH) : 1'b0;
        chk("valid", inst_valid, mvalid);
        if (mvalid) begin
            chk("inst_pc", inst_pc, q[0]);
            chk("inst_data", inst_data, mem_fn(q[0]));
        end
        chk("fault", fetch_fault, fault_exp);
        chk("req", imem_req, mreq);
        if (mreq || halted || !started)
            chk("addr", imem_addr, discard ? drain_addr : next_fetch);
        imem_ack = ack;
        inst_ready = rdy;
        redirect_valid = rv;
        redirect_pc = tgt;
        started = 1'b1;
        fault_exp = 1'b0;
        if (rv) begin
            q.delete();
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) begin
                halted = 1'b1;
                fault_exp = 1'b1;
                discard = 1'b0;
                next_fetch = tgt;
            end else
`endif
            begin
                halted = 1'b0;
                if (mreq && !ack) begin
                    if (!discard) drain_addr = next_fetch;
                    discard = 1'b1;
                end else
                    discard = 1'b0;
                next_fetch = tgt & ~32'h3;
            end
        end else begin
            if (mvalid && rdy) void'(q.pop_front());
            if (discard && ack)
                discard = 1'b0;
            else if (mreq && ack) begin
                q.push_back(next_fetch);
                next_fetch = next_fetch + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic ack, input logic rdy);
        for (int i = 0; i < n; i++) cycle(ack, rdy, 1'b0, 32'h0);
    endtask

    initial begin
        rstn = 1'b0;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset();
        rstn = 1'b1;
        // streaming with zero-wait memory
        run(8, 1'b1, 1'b1);
        // back-pressure fills the buffer, then release
        run(5, 1'b1, 1'b0);
        run(5, 1'b1, 1'b1);
        // redirect while a slow request is outstanding
        run(2, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h200);
        run(2, 1'b0, 1'b1);
        run(5, 1'b1, 1'b1);
        // redirect coinciding with ack and pop on a full buffer
        run(4, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h200);
        run(4, 1'b1, 1'b1);
        // address wrap
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        run(5, 1'b1, 1'b1);
        // misaligned redirect, then aligned recovery
        cycle(1'b1, 1'b1, 1'b1, 32'h202);
        run(3, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 32'h300);
        run(4, 1'b1, 1'b1);
        // reset asserted while a request is outstanding
        run(1, 1'b0, 1'b0);
        imem_ack = 1'b1;
        rstn = 1'b0;
        #1;
        chk_reset();
        model_reset();
        @(negedge clk);
        imem_ack = 1'b0;
        rstn = 1'b1;
        run(4, 1'b1, 1'b1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic rv;
            logic [31:0] tgt;
            rv = ($urandom % 16) == 0;
            tgt = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : $urandom;
            cycle(($urandom % 3) != 0, ($urandom % 4) != 0, rv, tgt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
